i2c_slave_responder: RTL



---
 rtl/i2c_responder_pkg.sv | 35 +++
 rtl/i2c_slave_responder_if.sv | 41 ++++
 rtl/i2c_bus_monitor.sv | 59 +++++
 rtl/i2c_slave_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_responder_pkg
//  Purpose  : Shared types and constants for the I2C slave responder.
//             state_t    - protocol FSM states
//             I2C_RW_*   - R/W bit encodings of the address byte
//             addr_match - address compare (general call never matches)
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_responder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic       I2C_RW_WRITE   = 1'b0;
  localparam logic       I2C_RW_READ    = 1'b1;
  localparam logic [7:0] UNDERFLOW_BYTE = 8'hFF;

  // The general-call address 7'h00 is not supported and never matches.
  function automatic logic addr_match(input logic [6:0] rx_addr,
                                      input logic [6:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_slave_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_responder_if
//  Purpose  : Bus pins and local data handshakes of the I2C slave responder.
//  Ports    : scl_i/sda_i (resolved bus), sda_oe_o (open-drain pull-down),
//             rx_* write-data sink handshake, tx_* read-data source handshake,
//             start_o/stop_o/busy_o/addr_hit_o status.
//             slave modport  - used by the responder
//             master modport - used by whatever drives the bus and handshakes
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       tx_req_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_underflow_o;
  logic       start_o;
  logic       stop_o;
  logic       busy_o;
  logic       addr_hit_o;

  modport slave (
    input  scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
    output sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, tx_underflow_o,
           start_o, stop_o, busy_o, addr_hit_o
  );

  modport master (
    output scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, tx_underflow_o,
           start_o, stop_o, busy_o, addr_hit_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_monitor
//  Purpose  : Synchronizes SCL/SDA, detects SCL edges and START/STOP.
//  Ports    : clk_i, rst_i        - system clock, sync active-high reset
//             scl_i, sda_i        - asynchronous bus inputs
//             scl_rise_o/fall_o   - one-cycle SCL edge strobes
//             sda_s_o             - synchronized SDA
//             start_det_o/stop_det_o - one-cycle START / STOP strobes
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_s_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Reset to the idle-bus level so leaving reset never fakes an event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_hist <= w_scl_s;
      r_sda_hist <= w_sda_s;
    end
  end

  assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign sda_s_o     = w_sda_s;
  assign scl_rise_o  =  w_scl_s & ~r_scl_hist;
  assign scl_fall_o  = ~w_scl_s &  r_scl_hist;
  // SDA edges only count as START/STOP while SCL stayed high across them.
  assign start_det_o = w_scl_s & r_scl_hist &  r_sda_hist & ~w_sda_s;
  assign stop_det_o  = w_scl_s & r_scl_hist & ~r_sda_hist &  w_sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_responder
//  Purpose  : Synthesizable I2C target: address match, write ACK/NACK through
//             rx valid/ready, read data through tx req/valid, no stretching.
//  Ports    : clk_i (>= 8x SCL), rst_i (sync, active high),
//             bus (i2c_slave_responder_if.slave) - pins and handshakes
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_responder
  import i2c_responder_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  i2c_slave_responder_if.slave  bus
);

  logic w_scl_rise, w_scl_fall, w_sda_s, w_start_det, w_stop_det;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (bus.scl_i),
    .sda_i       (bus.sda_i),
    .scl_rise_o  (w_scl_rise),
    .scl_fall_o  (w_scl_fall),
    .sda_s_o     (w_sda_s),
    .start_det_o (w_start_det),
    .stop_det_o  (w_stop_det)
  );

  state_t     r_state,    w_state;
  logic [2:0] r_bitcnt,   w_bitcnt;
  logic       r_phase,    w_phase;     // ACK phase entered / byte fully sent
  logic [6:0] r_shift,    w_shift;
  logic       r_rw,       w_rw;
  logic       r_ack_drv,  w_ack_drv;   // 1 = ACK the current write byte
  logic [7:0] r_tx_shift, w_tx_shift;
  logic       r_tx_pend,  w_tx_pend;
  logic       r_sda_oe,   w_sda_oe;
  logic [7:0] r_rx_data,  w_rx_data;
  logic       r_rx_valid, w_rx_valid;
  logic       r_tx_req,   w_tx_req;
  logic       r_uf,       w_uf;
  logic       r_start,    w_start;
  logic       r_stop,     w_stop;
  logic       r_busy,     w_busy;
  logic       r_hit,      w_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;  r_bitcnt <= 3'd0;  r_phase <= 1'b0;  r_shift <= 7'd0;
      r_rw <= 1'b0;  r_ack_drv <= 1'b0;  r_tx_shift <= 8'h00;  r_tx_pend <= 1'b0;
      r_sda_oe <= 1'b0;  r_rx_data <= 8'h00;  r_rx_valid <= 1'b0;  r_tx_req <= 1'b0;
      r_uf <= 1'b0;  r_start <= 1'b0;  r_stop <= 1'b0;  r_busy <= 1'b0;  r_hit <= 1'b0;
    end else begin
      r_state <= w_state;  r_bitcnt <= w_bitcnt;  r_phase <= w_phase;  r_shift <= w_shift;
      r_rw <= w_rw;  r_ack_drv <= w_ack_drv;  r_tx_shift <= w_tx_shift;  r_tx_pend <= w_tx_pend;
      r_sda_oe <= w_sda_oe;  r_rx_data <= w_rx_data;  r_rx_valid <= w_rx_valid;  r_tx_req <= w_tx_req;
      r_uf <= w_uf;  r_start <= w_start;  r_stop <= w_stop;  r_busy <= w_busy;  r_hit <= w_hit;
    end
  end

  always_comb begin
    w_state = r_state;  w_bitcnt = r_bitcnt;  w_phase = r_phase;  w_shift = r_shift;
    w_rw = r_rw;  w_ack_drv = r_ack_drv;  w_tx_shift = r_tx_shift;  w_sda_oe = r_sda_oe;
    w_rx_data = r_rx_data;  w_busy = r_busy;  w_hit = r_hit;
    w_rx_valid = 1'b0;  w_tx_req = 1'b0;  w_uf = 1'b0;  w_start = 1'b0;  w_stop = 1'b0;
    w_tx_pend = r_tx_req;

    // Read byte is captured the cycle after the request strobe.
    if (r_tx_pend) begin
      if (bus.tx_valid_i) begin
        w_tx_shift = bus.tx_data_i;
      end else begin
        w_tx_shift = UNDERFLOW_BYTE;
        w_uf       = 1'b1;
      end
    end

    if (w_stop_det) begin
      w_state = IDLE;  w_stop = 1'b1;  w_busy = 1'b0;  w_hit = 1'b0;
      w_sda_oe = 1'b0;  w_bitcnt = 3'd0;  w_phase = 1'b0;
    end else if (w_start_det) begin
      // SDA drive is left alone here and released on the next SCL fall.
      w_state = ADDR;  w_start = 1'b1;  w_busy = 1'b1;  w_hit = 1'b0;
      w_bitcnt = 3'd0;  w_phase = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR: begin
          if (w_scl_fall) w_sda_oe = 1'b0;
          if (w_scl_rise) begin
            w_shift  = {r_shift[5:0], w_sda_s};
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_rw = w_sda_s;
              if (addr_match(r_shift, SLAVE_ADDR)) begin
                w_state = ADDR_ACK;  w_hit = 1'b1;  w_phase = 1'b0;
              end else begin
                w_state = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe = 1'b1;  w_phase = 1'b1;
            end else if (r_rw == I2C_RW_WRITE) begin
              w_sda_oe = 1'b0;  w_state = WR_BYTE;  w_phase = 1'b0;  w_bitcnt = 3'd0;
            end
          end
          // For reads the ACK is replaced by the first data bit at the next fall.
          if (w_scl_rise && r_phase && r_rw == I2C_RW_READ) begin
            w_tx_req = 1'b1;  w_state = RD_BYTE;  w_phase = 1'b0;  w_bitcnt = 3'd0;
          end
        end
        WR_BYTE: begin
          if (w_scl_fall) w_sda_oe = 1'b0;
          if (w_scl_rise) begin
            w_shift  = {r_shift[5:0], w_sda_s};
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_rx_data  = {r_shift, w_sda_s};
              w_rx_valid = 1'b1;
              w_ack_drv  = bus.rx_ready_i;
              w_state    = WR_ACK;
              w_phase    = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe = r_ack_drv;  w_phase = 1'b1;
            end else begin
              w_sda_oe = 1'b0;  w_state = WR_BYTE;  w_phase = 1'b0;  w_bitcnt = 3'd0;
            end
          end
        end
        RD_BYTE: begin
          if (w_scl_rise) begin
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) w_phase = 1'b1;
          end
          if (w_scl_fall) begin
            if (r_phase) begin
              w_sda_oe = 1'b0;  w_state = RD_ACK;  w_phase = 1'b0;
            end else begin
              // After k rises the bit to present is bit 7-k (MSB first).
              w_sda_oe = ~r_tx_shift[3'd7 - r_bitcnt];
            end
          end
        end
        RD_ACK: begin
          if (w_scl_fall) w_sda_oe = 1'b0;
          if (w_scl_rise) begin
            if (!w_sda_s) begin
              w_tx_req = 1'b1;  w_state = RD_BYTE;  w_bitcnt = 3'd0;  w_phase = 1'b0;
            end else begin
              w_state = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          if (w_scl_fall) w_sda_oe = 1'b0;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.sda_oe_o       = r_sda_oe;
  assign bus.rx_data_o      = r_rx_data;
  assign bus.rx_valid_o     = r_rx_valid;
  assign bus.tx_req_o       = r_tx_req;
  assign bus.tx_underflow_o = r_uf;
  assign bus.start_o        = r_start;
  assign bus.stop_o         = r_stop;
  assign bus.busy_o         = r_busy;
  assign bus.addr_hit_o     = r_hit;

endmodule
`default_nettype wire
